// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, operand-select codes
// and FSM state encoding.
package control_unit_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_e;

  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_JAL  = 6'b110011;
  localparam logic [5:0] OP_RET  = 6'b111000;
  localparam logic [5:0] OP_IN   = 6'b111001;
  localparam logic [5:0] OP_OUT  = 6'b111010;
  localparam logic [5:0] OP_PUSH = 6'b111011;
  localparam logic [5:0] OP_POP  = 6'b111100;
  localparam logic [5:0] OP_RETI = 6'b111101;
  localparam logic [5:0] OP_EI   = 6'b111110;
  localparam logic [5:0] OP_DI   = 6'b111111;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_PORT  = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  // Instructions that redirect the PC themselves; an interrupt must not
  // steal the PC from them.
  function automatic logic isControlFlow(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JZ) || (op == OP_JNZ) ||
           (op == OP_JAL) || (op == OP_RET) || (op == OP_RETI);
  endfunction

endpackage

// File: rtl/control_unit_depth_counter.sv
// Stack occupancy tracker: counts pushes and pops between 0 and MAX and
// raises sticky flags when a push hits a full stack or a pop an empty one.
module depth_counter #(
  parameter int MAX = 16,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic ovf_o,
  output logic unf_o
);

  logic [W-1:0] depth_q;
  logic         ovf_q;
  logic         unf_q;

  assign full_o  = (depth_q == W'(MAX));
  assign empty_o = (depth_q == '0);
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  // Refused operations leave the depth alone and only latch the error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push_i) begin
      if (full_o) ovf_q <= 1'b1;
      else        depth_q <= depth_q + W'(1);
    end else if (pop_i) begin
      if (empty_o) unf_q <= 1'b1;
      else         depth_q <= depth_q - W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder and interrupt controller. Control signals are decoded
// combinationally from the opcode, the zero flag and the current state;
// only the run/ISR state, interrupt enable and stack depths are registered.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int DS_DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       s_interruption,
  output logic       s_4mux1,
  output logic       s_4mux2,
  output logic       s_4mux3,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic [1:0] sel_inputs,
  output logic       s_we_port,
  output logic       s_we_stack,
  output logic       s_jalret,
  output logic       s_we_stack_data,
  output logic       s_pushpop,
  output logic       s_finished,
  output logic       int_en,
  output logic       stk_ovf,
  output logic       stk_unf
);

  state_e state_q;
  logic   int_en_q;

  logic rsPushReq, rsPopReq, dsPushReq, dsPopReq;
  logic rsFull, rsEmpty, dsFull, dsEmpty;
  logic rsOvf, rsUnf, dsOvf, dsUnf;
  logic takeJump, accept;
  logic we3Dec, wezDec, portDec;

  assign int_en  = int_en_q;
  assign stk_ovf = rsOvf | dsOvf;
  assign stk_unf = rsUnf | dsUnf;

  // An interrupt is taken only from RUN, never in the EI cycle, never on a
  // PC-redirecting instruction, and is deferred while the return stack (or,
  // for a PUSH, the data stack) is full so deferral itself raises no error.
  always_comb begin
    accept = (state_q == ST_RUN) && int_en_q && s_interruption && !rsFull &&
             !isControlFlow(opcode) && (opcode != OP_EI) &&
             !((opcode == OP_PUSH) && dsFull);
  end

  // Main decode: register/port writes, stack requests and the PC path.
  always_comb begin
    we3Dec     = 1'b0;
    wezDec     = 1'b0;
    portDec    = 1'b0;
    op_alu     = 3'b000;
    sel_inputs = SEL_ALU;
    rsPushReq  = 1'b0;
    rsPopReq   = 1'b0;
    dsPushReq  = 1'b0;
    dsPopReq   = 1'b0;
    takeJump   = 1'b0;
    casez (opcode)
      6'b0?????: begin
        we3Dec = 1'b1;
        wezDec = 1'b1;
        op_alu = opcode[4:2];
      end
      6'b1000??: begin
        we3Dec     = 1'b1;
        sel_inputs = SEL_IMM;
      end
      OP_J:   takeJump = 1'b1;
      OP_JZ:  takeJump = z;
      OP_JNZ: takeJump = !z;
      OP_JAL: begin
        takeJump  = 1'b1;
        rsPushReq = 1'b1;
      end
      OP_RET, OP_RETI: rsPopReq = 1'b1;
      OP_IN: begin
        we3Dec     = 1'b1;
        sel_inputs = SEL_PORT;
      end
      OP_OUT:  portDec   = 1'b1;
      OP_PUSH: dsPushReq = 1'b1;
      OP_POP: begin
        dsPopReq   = 1'b1;
        we3Dec     = 1'b1;
        sel_inputs = SEL_STACK;
      end
      default: ;
    endcase

    if (accept) rsPushReq = 1'b1;

    s_4mux1 = 1'b1;
    s_4mux2 = 1'b0;
    s_4mux3 = 1'b0;
    if (accept) begin
      s_4mux1 = 1'b0;
    end else if (takeJump) begin
      s_4mux1 = 1'b0;
      s_4mux2 = 1'b1;
    end else if (rsPopReq && !rsEmpty) begin
      s_4mux3 = 1'b1;
    end

    s_jalret        = rsPushReq;
    s_pushpop       = dsPushReq;
    s_we_stack      = !reset && ((rsPushReq && !rsFull) || (rsPopReq && !rsEmpty));
    s_we_stack_data = !reset && ((dsPushReq && !dsFull) || (dsPopReq && !dsEmpty));
    we3             = !reset && we3Dec;
    wez             = !reset && wezDec;
    s_we_port       = !reset && portDec;
    s_finished      = !reset && (state_q == ST_ISR) && (opcode == OP_RETI);
  end

  // Run/ISR state machine with the interrupt-enable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      int_en_q <= 1'b0;
    end else begin
      if (opcode == OP_EI) int_en_q <= 1'b1;
      if (opcode == OP_DI) int_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            state_q  <= ST_ISR;
            int_en_q <= 1'b0;
          end
        end
        ST_ISR: begin
          if (opcode == OP_RETI) begin
            state_q  <= ST_RUN;
            int_en_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  depth_counter #(.MAX(RS_DEPTH)) u_rsDepth (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsPushReq),
    .pop_i   (rsPopReq),
    .full_o  (rsFull),
    .empty_o (rsEmpty),
    .ovf_o   (rsOvf),
    .unf_o   (rsUnf)
  );

  depth_counter #(.MAX(DS_DEPTH)) u_dsDepth (
    .clk     (clk),
    .reset   (reset),
    .push_i  (dsPushReq),
    .pop_i   (dsPopReq),
    .full_o  (dsFull),
    .empty_o (dsEmpty),
    .ovf_o   (dsOvf),
    .unf_o   (dsUnf)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle pushes the expected
// outputs computed by a behavioural model; a negedge monitor pops and compares.
module tb_control_unit;

  logic       clk, reset, z, s_interruption;
  logic [5:0] opcode;
  logic       s_4mux1, s_4mux2, s_4mux3, we3, wez;
  logic [2:0] op_alu;
  logic [1:0] sel_inputs;
  logic       s_we_port, s_we_stack, s_jalret, s_we_stack_data, s_pushpop;
  logic       s_finished, int_en, stk_ovf, stk_unf;

  typedef struct {
    string       tag;
    logic [15:0] outs;
    logic [2:0]  flags;
  } expItem_t;

  expItem_t expQ[$];
  int checks = 0;
  int passes = 0;

  logic mIsr, mIntEn, mOvf, mUnf;
  int   mRs, mDs;

  control_unit #(.RS_DEPTH(16), .DS_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .s_interruption(s_interruption),
    .s_4mux1(s_4mux1), .s_4mux2(s_4mux2), .s_4mux3(s_4mux3),
    .we3(we3), .wez(wez), .op_alu(op_alu), .sel_inputs(sel_inputs),
    .s_we_port(s_we_port), .s_we_stack(s_we_stack), .s_jalret(s_jalret),
    .s_we_stack_data(s_we_stack_data), .s_pushpop(s_pushpop),
    .s_finished(s_finished), .int_en(int_en),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    else
      passes++;
  endtask

  // Drive one cycle, predict the outputs from the model, advance the model.
  task automatic applyStimulus(input string tag, input logic [5:0] op,
                               input logic zIn, input logic irqIn, input logic rstIn);
    logic m1, m2, m3, w3, wz, port, rsEn, jr, dsEn, pp, fin;
    logic [2:0] alu;
    logic [1:0] sel;
    logic rsPush, rsPop, dsPush, dsPop, jump, ctl, acc;
    expItem_t e;
    opcode = op; z = zIn; s_interruption = irqIn; reset = rstIn;
    m1 = 1; m2 = 0; m3 = 0; w3 = 0; wz = 0; port = 0; rsEn = 0; dsEn = 0;
    fin = 0; alu = 0; sel = 0; rsPush = 0; rsPop = 0; dsPush = 0; dsPop = 0;
    jump = 0;
    ctl = (op == 6'b110000) || (op == 6'b110001) || (op == 6'b110010) ||
          (op == 6'b110011) || (op == 6'b111000) || (op == 6'b111101);
    if (op[5] == 1'b0) begin w3 = 1; wz = 1; alu = op[4:2]; end
    else if (op[5:2] == 4'b1000) begin w3 = 1; sel = 2'b11; end
    else if (op == 6'b110000) jump = 1;
    else if (op == 6'b110001) jump = zIn;
    else if (op == 6'b110010) jump = !zIn;
    else if (op == 6'b110011) begin jump = 1; rsPush = 1; end
    else if (op == 6'b111000 || op == 6'b111101) rsPop = 1;
    else if (op == 6'b111001) begin w3 = 1; sel = 2'b01; end
    else if (op == 6'b111010) port = 1;
    else if (op == 6'b111011) dsPush = 1;
    else if (op == 6'b111100) begin dsPop = 1; w3 = 1; sel = 2'b10; end
    acc = !mIsr && mIntEn && irqIn && (mRs < 16) && !ctl && (op != 6'b111110) &&
          !(op == 6'b111011 && mDs == 64);
    if (acc) rsPush = 1;
    if (acc) m1 = 0;
    else if (jump) begin m1 = 0; m2 = 1; end
    else if (rsPop && mRs > 0) m3 = 1;
    if (op == 6'b111101 && mIsr) fin = 1;
    jr = rsPush;
    pp = dsPush;
    rsEn = (rsPush && mRs < 16) || (rsPop && mRs > 0);
    dsEn = (dsPush && mDs < 64) || (dsPop && mDs > 0);
    if (rstIn) begin w3 = 0; wz = 0; port = 0; rsEn = 0; dsEn = 0; fin = 0; end
    e.tag   = tag;
    e.outs  = {m1, m2, m3, w3, wz, alu, sel, port, rsEn, jr, dsEn, pp, fin};
    e.flags = {mIntEn, mOvf, mUnf};
    expQ.push_back(e);
    if (rstIn) begin
      mIsr = 0; mIntEn = 0; mRs = 0; mDs = 0; mOvf = 0; mUnf = 0;
    end else begin
      if (rsPush) begin if (mRs == 16) mOvf = 1; else mRs++; end
      if (rsPop)  begin if (mRs == 0)  mUnf = 1; else mRs--; end
      if (dsPush) begin if (mDs == 64) mOvf = 1; else mDs++; end
      if (dsPop)  begin if (mDs == 0)  mUnf = 1; else mDs--; end
      if (op == 6'b111110) mIntEn = 1;
      if (op == 6'b111111) mIntEn = 0;
      if (acc) begin mIsr = 1; mIntEn = 0; end
      else if (mIsr && op == 6'b111101) begin mIsr = 0; mIntEn = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT outputs of the current cycle against the oldest prediction.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      expItem_t e;
      e = expQ.pop_front();
      checkOutput({e.tag, ".outs"},
                  {16'h0, s_4mux1, s_4mux2, s_4mux3, we3, wez, op_alu, sel_inputs,
                   s_we_port, s_we_stack, s_jalret, s_we_stack_data, s_pushpop,
                   s_finished}, {16'h0, e.outs});
      checkOutput({e.tag, ".flags"}, {29'h0, int_en, stk_ovf, stk_unf},
                  {29'h0, e.flags});
    end
  end

  initial begin
    reset = 1; opcode = 0; z = 0; s_interruption = 0;
    mIsr = 0; mIntEn = 0; mRs = 0; mDs = 0; mOvf = 0; mUnf = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("aluAfterReset", 6'b000100, 0, 0, 0);
    applyStimulus("jzTaken",       6'b110001, 1, 0, 0);
    applyStimulus("jzUntaken",     6'b110001, 0, 0, 0);
    applyStimulus("jnzTaken",      6'b110010, 0, 0, 0);
    applyStimulus("jump",          6'b110000, 0, 0, 0);
    applyStimulus("li",            6'b100010, 0, 0, 0);
    applyStimulus("in",            6'b111001, 0, 0, 0);
    applyStimulus("out",           6'b111010, 0, 0, 0);
    applyStimulus("nopA",          6'b100101, 0, 0, 0);
    applyStimulus("nopB",          6'b101110, 0, 0, 0);
    applyStimulus("popEmpty",      6'b111100, 0, 0, 0);
    applyStimulus("push",          6'b111011, 0, 0, 0);
    applyStimulus("pop",           6'b111100, 0, 0, 0);
    applyStimulus("aluInReset",    6'b011100, 0, 0, 1);
    for (int i = 0; i < 17; i++)
      applyStimulus($sformatf("jal%0d", i), 6'b110011, 0, 0, 0);
    applyStimulus("retAfterOvf",   6'b111000, 0, 0, 0);
    applyStimulus("ovfSticky",     6'b000000, 0, 0, 0);
    applyStimulus("resetOvf",      6'b000000, 0, 0, 1);
    applyStimulus("ei",            6'b111110, 0, 1, 0);
    applyStimulus("liAccept",      6'b100000, 0, 1, 0);
    applyStimulus("liIgnored",     6'b100000, 0, 1, 0);
    applyStimulus("eiInIsr",       6'b111110, 0, 1, 0);
    applyStimulus("stillBlocked",  6'b000100, 0, 1, 0);
    applyStimulus("retiIsr",       6'b111101, 0, 0, 0);
    applyStimulus("afterReti",     6'b100100, 0, 1, 0);
    applyStimulus("retiIsr2",      6'b111101, 0, 0, 0);
    applyStimulus("retiRun",       6'b111101, 0, 0, 0);
    applyStimulus("jalA",          6'b110011, 0, 0, 0);
    applyStimulus("jalB",          6'b110011, 0, 0, 0);
    applyStimulus("acceptDepth3",  6'b111010, 0, 1, 0);
    applyStimulus("resetInIsr",    6'b111101, 0, 0, 1);
    applyStimulus("afterIsrReset", 6'b111101, 0, 1, 0);
    applyStimulus("deferDi",       6'b111111, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      applyStimulus($sformatf("rand%0d", i), 6'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 40) == 0));
    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameters RS_DEPTH (default 16, return-stack entries) and DS_DEPTH (default 64, data-stack entries).
REQ-002 SHALL have one clock; reset is synchronous and active-high (ports clk, reset).
REQ-003 Ports: clk in 1 clock; reset in 1 sync active-high reset; opcode in 6 instr[15:10]; z in 1 registered zero flag; s_interruption in 1 interrupt request level.
REQ-004 Ports: s_4mux1, s_4mux2, s_4mux3 out 1 PC-path selects; we3 out 1 regfile write; wez out 1 Z-flag write; op_alu out 3; sel_inputs out 2 (00 ALU, 01 port, 10 data stack, 11 immediate).
REQ-005 Ports: s_we_port out 1; s_we_stack out 1 return-stack enable; s_jalret out 1 (1 push, 0 pop); s_we_stack_data out 1; s_pushpop out 1 (1 push, 0 pop).
REQ-006 Ports: s_finished out 1 ISR-done pulse; int_en out 1 interrupt-enable state; stk_ovf, stk_unf out 1 sticky stack-error flags.

Function
REQ-007 Decode SHALL be combinational from opcode, z and state; registered state only in REQ-013..REQ-018.
REQ-008 Encodings: 0aaaxx ALU (op_alu=opcode[4:2], we3=1, wez=1, sel 00); 1000xx LI (we3=1, sel 11); 1001xx and 101xxx NOP (no writes).
REQ-009 Encodings: 110000 J; 110001 JZ (taken if z=1); 110010 JNZ (taken if z=0); 110011 JAL (push PC+1, jump).
REQ-010 Encodings: 111000 RET (pop, PC=stack); 111001 IN (we3, sel 01); 111010 OUT (s_we_port); 111011 PUSH (data push); 111100 POP (data pop, we3, sel 10); 111101 RETI; 111110 EI; 111111 DI.
REQ-011 PC selects: sequential s_4mux1=1, s_4mux3=0; jump s_4mux1=0, s_4mux2=1; return s_4mux1=1, s_4mux3=1; vector s_4mux1=0, s_4mux2=0.
REQ-012 Untaken JZ/JNZ SHALL act as NOP with sequential PC.
REQ-013 SHALL keep a return-stack depth counter (0..RS_DEPTH): +1 per push, -1 per pop.
REQ-014 SHALL keep a data-stack depth counter (0..DS_DEPTH) with the same rules.
REQ-015 A push at depth = max SHALL force s_we_stack/s_we_stack_data=0, set stk_ovf, and leave depth unchanged; PC flow is still as decoded.
REQ-016 A pop at depth 0 SHALL force the enable to 0 and set stk_unf. POP still writes the register. RET/RETI falls to the sequential PC.
REQ-017 FSM states: RUN, ISR. An interrupt is accepted when state=RUN, int_en=1, s_interruption=1, depth<RS_DEPTH and the current opcode is not J/JZ/JNZ/JAL/RET/RETI.
REQ-018 On acceptance, the current instruction SHALL execute its data writes. PC takes the vector. PC+1 is pushed onto the return stack. Next state is ISR, int_en clears, and depth is +1.
REQ-019 In ISR, further interrupts SHALL be ignored. EI in ISR sets int_en but nesting stays blocked until return to RUN.
REQ-020 RETI in ISR SHALL pop, return, pulse s_finished for exactly 1 cycle, set int_en=1, and go to RUN.
REQ-021 RETI in RUN SHALL behave as RET with no s_finished pulse.
REQ-022 EI and DI SHALL take effect on the next cycle; an interrupt is not accepted in the EI cycle itself.
REQ-023 Interrupt acceptance while the current opcode is PUSH/JAL-class at the limit SHALL be deferred; stk_ovf is not set by deferral.

Reset
REQ-024 On reset: state RUN, int_en=0, both depths 0, stk_ovf=stk_unf=0, s_finished=0; takes priority over all same-cycle events.
REQ-025 While reset=1, all write enables (we3, wez, s_we_port, s_we_stack, s_we_stack_data) SHALL be 0.
REQ-026 Reset mid-ISR SHALL return to RUN without an s_finished pulse.

Structure
REQ-027 Opcode constants, sel_inputs codes and FSM state encodings SHALL reside in a shared package used by control_unit and cd.
REQ-028 One sub-module, depth_counter (parameterised max, push/pop in, ovf/unf out), SHALL be instantiated twice.

Verification
REQ-029 Reset, then ALU op 000100 with z=0 -> we3=1, wez=1, op_alu=001, sel 00, s_4mux1=1, s_4mux3=0.
REQ-030 JZ with z=1 -> s_4mux1=0, s_4mux2=1; with z=0 -> sequential PC, no writes.
REQ-031 17 consecutive JALs (RS_DEPTH=16) -> 16 pushes; 17th has s_we_stack=0, stk_ovf=1 sticky until reset.
REQ-032 EI, then s_interruption=1 during LI -> we3=1, vector selected, push, state ISR, int_en=0; second request ignored; RETI -> s_finished pulse, int_en=1, RUN.
REQ-033 POP at data depth 0 -> s_we_stack_data=0, stk_unf=1, we3=1.
REQ-034 Reset asserted in ISR at depth 3 -> next cycle RUN, depths 0, int_en=0, no s_finished.
